// File: rtl/nem_ohmux_seq_ctrl.sv
// nem_ohmux_seq_ctrl
// Sequenced one-hot NEM relay select controller with an inverting NOR data path.
// Relay changes are break-before-make: the old relay is released and T_OPEN
// cycles elapse before the new relay is driven, then T_CLOSE cycles elapse
// before ZN is flagged valid.
// Optional build macro NEM_OHMUX_HOLD_EN: adds a hold register so that ZN shows
// the last settled value while a relay change is in flight.
module nem_ohmux_seq_ctrl #(
    parameter int NIN     = 4,
    parameter int WIDTH   = 8,
    parameter int T_OPEN  = 3,
    parameter int T_CLOSE = 5
) (
    input  logic                       CP,
    input  logic                       CDN,
    input  logic                       REQ_VLD,
    input  logic [$clog2(NIN):0]       REQ_SEL,
    output logic                       REQ_RDY,
    input  logic [NIN*WIDTH-1:0]       I,
    output logic [NIN-1:0]             S,
    output logic [WIDTH-1:0]           ZN,
    output logic                       ZN_VLD,
    output logic [$clog2(NIN)-1:0]     CUR_SEL,
    output logic                       ERR
);

    localparam int SW   = $clog2(NIN);
    localparam int SELW = SW + 1;
    localparam int TMAX = (T_OPEN > T_CLOSE) ? T_OPEN : T_CLOSE;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0]   OPEN_LOAD  = CW'(T_OPEN - 1);
    localparam logic [CW-1:0]   CLOSE_LOAD = CW'(T_CLOSE - 1);
    localparam logic [SELW-1:0] NIN_SEL    = SELW'(NIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_ON    = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [SELW-1:0]   pend_r;
    logic              req_in_range_s;
    logic              pend_in_range_s;
    logic              accept_s;
    logic [WIDTH-1:0]  zn_or_s;
    logic [WIDTH-1:0]  zn_live_s;

    // One-hot gate pattern for an in-range index; all zero otherwise
    function automatic logic [NIN-1:0] onehot(input logic [SELW-1:0] idx);
        logic [NIN-1:0] oh;
        oh = {NIN{1'b0}};
        for (int k = 0; k < NIN; k++) begin
            if (idx == SELW'(k)) begin
                oh[k] = 1'b1;
            end else begin
                oh[k] = 1'b0;
            end
        end
        return oh;
    endfunction

    assign req_in_range_s  = (REQ_SEL < NIN_SEL);
    assign pend_in_range_s = (pend_r < NIN_SEL);
    assign accept_s        = REQ_VLD & REQ_RDY;

    // Relay sequencing FSM; every output it drives is registered
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            pend_r  <= {SELW{1'b0}};
            S       <= {NIN{1'b0}};
            ZN_VLD  <= 1'b0;
            CUR_SEL <= {SW{1'b0}};
            ERR     <= 1'b0;
            REQ_RDY <= 1'b1;
        end else begin
            ERR <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (req_in_range_s) begin
                            state_r <= ST_MAKE;
                            S       <= onehot(REQ_SEL);
                            CUR_SEL <= REQ_SEL[SW-1:0];
                            cnt_r   <= CLOSE_LOAD;
                            REQ_RDY <= 1'b0;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    // Re-selecting the connected input is a no-op
                    if (accept_s && (REQ_SEL != {1'b0, CUR_SEL})) begin
                        state_r <= ST_BREAK;
                        S       <= {NIN{1'b0}};
                        ZN_VLD  <= 1'b0;
                        cnt_r   <= OPEN_LOAD;
                        pend_r  <= REQ_SEL;
                        REQ_RDY <= 1'b0;
                        ERR     <= ~req_in_range_s;
                    end
                end
                ST_BREAK: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        if (pend_in_range_s) begin
                            state_r <= ST_MAKE;
                            S       <= onehot(pend_r);
                            CUR_SEL <= pend_r[SW-1:0];
                            cnt_r   <= CLOSE_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                            REQ_RDY <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_MAKE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_ON;
                        ZN_VLD  <= 1'b1;
                        REQ_RDY <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    S       <= {NIN{1'b0}};
                    ZN_VLD  <= 1'b0;
                    REQ_RDY <= 1'b1;
                end
            endcase
        end
    end

    // Live inverting NOR of the gated inputs; all ones with every relay open
    always_comb begin
        zn_or_s = {WIDTH{1'b0}};
        for (int k = 0; k < NIN; k++) begin
            zn_or_s = zn_or_s | (I[k*WIDTH +: WIDTH] & {WIDTH{S[k]}});
        end
        zn_live_s = ~zn_or_s;
    end

`ifdef NEM_OHMUX_HOLD_EN
    logic [WIDTH-1:0] hold_r;

    // Track the settled output so it can be presented while relays move
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            hold_r <= {WIDTH{1'b1}};
        end else if (ZN_VLD) begin
            hold_r <= zn_live_s;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Show the held value during BREAK/MAKE, the live NOR otherwise
    always_comb begin
        if ((state_r == ST_BREAK) || (state_r == ST_MAKE)) begin
            ZN = hold_r;
        end else begin
            ZN = zn_live_s;
        end
    end
`else
    assign ZN = zn_live_s;
`endif

endmodule

// File: tb/tb_nem_ohmux_seq_ctrl.sv
// Self-checking bench for nem_ohmux_seq_ctrl (default parameters).
// Expected settled results are queued when a request is driven and compared
// when ZN_VLD rises; one-hot and break-before-make are checked every cycle.
module tb_nem_ohmux_seq_ctrl;

    localparam int NIN   = 4;
    localparam int WIDTH = 8;
`ifdef NEM_OHMUX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic                   CP;
    logic                   CDN;
    logic                   REQ_VLD;
    logic [2:0]             REQ_SEL;
    logic                   REQ_RDY;
    logic [NIN*WIDTH-1:0]   I;
    logic [NIN-1:0]         S;
    logic [WIDTH-1:0]       ZN;
    logic                   ZN_VLD;
    logic [1:0]             CUR_SEL;
    logic                   ERR;

    typedef struct {
        logic [3:0] s;
        logic [7:0] zn;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests;
    int         n_fail;
    int         cyc;
    logic [3:0] prev_s;
    logic       prev_vld;

    nem_ohmux_seq_ctrl #(
        .NIN(NIN), .WIDTH(WIDTH), .T_OPEN(3), .T_CLOSE(5)
    ) dut (
        .CP(CP), .CDN(CDN), .REQ_VLD(REQ_VLD), .REQ_SEL(REQ_SEL),
        .REQ_RDY(REQ_RDY), .I(I), .S(S), .ZN(ZN), .ZN_VLD(ZN_VLD),
        .CUR_SEL(CUR_SEL), .ERR(ERR)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] inv_in(input int k);
        logic [31:0] d;
        d = I;
        return ~d[k*8 +: 8];
    endfunction

    // Advance one cycle, then run the per-cycle invariant checks and the scoreboard monitor
    task automatic tick();
        exp_t e;
        @(posedge CP);
        #1;
        cyc++;
        chk("onehot", 32'($countones(S) <= 1), 32'd1);
        if (prev_s != 4'b0000 && S != 4'b0000) chk("bbm", 32'(S), 32'(prev_s));
        if (ZN_VLD && !prev_vld) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_s", 32'(S), 32'(e.s));
                chk("sb_zn", 32'(ZN), 32'(e.zn));
                chk("sb_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        prev_s   = S;
        prev_vld = ZN_VLD;
    endtask

    task automatic push_exp(input int sel, input int lat);
        exp_t e;
        e.s   = 4'b0001 << sel;
        e.zn  = inv_in(sel);
        e.acc = cyc + 1;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic request(input logic [2:0] sel);
        chk("rdy_pre", 32'(REQ_RDY), 32'd1);
        REQ_VLD = 1'b1;
        REQ_SEL = sel;
        tick();
        REQ_VLD = 1'b0;
    endtask

    task automatic wait_vld(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("vld_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        prev_s   = 4'b0000;
        prev_vld = 1'b0;
        CDN      = 1'b0;
        REQ_VLD  = 1'b0;
        REQ_SEL  = 3'd0;
        I        = {8'hC3, 8'h0F, 8'h3C, 8'hA5};

        // Reset state
        tick();
        tick();
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_vld", 32'(ZN_VLD), 32'd0);
        chk("rst_cur", 32'(CUR_SEL), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_rdy", 32'(REQ_RDY), 32'd1);
        chk("rst_zn", 32'(ZN), 32'hFF);
        CDN = 1'b1;
        tick();

        // IDLE -> select 2: S one cycle after accept, ZN_VLD 5 cycles after
        push_exp(2, 5);
        request(3'd2);
        chk("t1_s", 32'(S), 32'h4);
        chk("t1_rdy", 32'(REQ_RDY), 32'd0);
        chk("t1_vld", 32'(ZN_VLD), 32'd0);
        chk("t1_zn_make", 32'(ZN), HOLD ? 32'hFF : 32'hF0);
        wait_vld(20);

        // ON 2 -> 0: three open cycles, a request during BREAK is ignored
        push_exp(0, 8);
        request(3'd0);
        chk("t2_s_open0", 32'(S), 32'd0);
        chk("t2_err", 32'(ERR), 32'd0);
        chk("t2_zn_break", 32'(ZN), HOLD ? 32'hF0 : 32'hFF);
        REQ_VLD = 1'b1;
        REQ_SEL = 3'd1;
        tick();
        REQ_VLD = 1'b0;
        chk("t2_s_open1", 32'(S), 32'd0);
        tick();
        chk("t2_s_open2", 32'(S), 32'd0);
        tick();
        chk("t2_s_make", 32'(S), 32'h1);
        chk("t2_cur", 32'(CUR_SEL), 32'd0);
        wait_vld(20);

        // ON 0 -> 3: ZN through the whole transition
        push_exp(3, 8);
        request(3'd3);
        for (int i = 0; i < 8; i++) begin
            chk("t3_zn_trans", 32'(ZN), HOLD ? 32'h5A : ((i < 3) ? 32'hFF : 32'h3C));
            if (i < 7) tick();
        end
        wait_vld(20);

        // ON 3 -> 1, then re-request 1 as a no-op
        push_exp(1, 8);
        request(3'd1);
        wait_vld(20);
        request(3'd1);
        chk("t4_s", 32'(S), 32'h2);
        chk("t4_vld", 32'(ZN_VLD), 32'd1);
        chk("t4_rdy", 32'(REQ_RDY), 32'd1);
        chk("t4_err", 32'(ERR), 32'd0);
        tick();
        chk("t4_s_hold", 32'(S), 32'h2);
        chk("t4_vld_hold", 32'(ZN_VLD), 32'd1);

        // ON, out-of-range 7: ERR pulse, open relay, IDLE after T_OPEN
        request(3'd7);
        chk("t5_err", 32'(ERR), 32'd1);
        chk("t5_s", 32'(S), 32'd0);
        chk("t5_vld", 32'(ZN_VLD), 32'd0);
        chk("t5_zn", 32'(ZN), HOLD ? 32'hC3 : 32'hFF);
        tick();
        chk("t5_err_pulse", 32'(ERR), 32'd0);
        chk("t5_rdy1", 32'(REQ_RDY), 32'd0);
        tick();
        chk("t5_rdy2", 32'(REQ_RDY), 32'd0);
        tick();
        chk("t5_rdy_idle", 32'(REQ_RDY), 32'd1);
        chk("t5_zn_idle", 32'(ZN), 32'hFF);
        chk("t5_cur", 32'(CUR_SEL), 32'd1);

        // IDLE, out-of-range 5: ERR pulse, stays IDLE
        request(3'd5);
        chk("t6_err", 32'(ERR), 32'd1);
        chk("t6_rdy", 32'(REQ_RDY), 32'd1);
        chk("t6_s", 32'(S), 32'd0);
        tick();
        chk("t6_err_pulse", 32'(ERR), 32'd0);

        // Reset during MAKE: relay drops asynchronously, comes back in IDLE
        request(3'd3);
        chk("t7_s_make", 32'(S), 32'h8);
        tick();
        tick();
        #2;
        CDN = 1'b0;
        #1;
        chk("t7_s_async", 32'(S), 32'd0);
        chk("t7_vld_async", 32'(ZN_VLD), 32'd0);
        chk("t7_rdy_async", 32'(REQ_RDY), 32'd1);
        chk("t7_zn_async", 32'(ZN), 32'hFF);
        tick();
        CDN = 1'b1;
        tick();
        chk("t7_rdy", 32'(REQ_RDY), 32'd1);
        chk("t7_cur", 32'(CUR_SEL), 32'd0);
        push_exp(2, 5);
        request(3'd2);
        wait_vld(20);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
